x86_prefix_fetch: RTL
=====================

# x86_prefix_fetch

Parametrised byte-stream front end for the x86 core: consumes instruction bytes one per cycle, accumulates prefixes (segment override, LOCK, REP/REPZ/REPNZ), recognises the 0x0F escape, and emits one decoded opcode bundle per instruction over a valid/ready handshake. It sits between the memory byte port and the execute sequencer. It also tracks the fetch IP and the instruction start IP, and flags over-long prefix chains.

## Interface
Parameters:
- IP_W, 16, width of instruction pointer
- RESET_IP, 16'h8000, IP after reset ("PostBios" start)
- MAX_PREFIX, 14, prefixes accepted before fault; count width PC_W = $clog2(MAX_PREFIX+1)

Ports (one clock; reset is synchronous and active-high):
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_data holds byte at ip
- in_data  in  8  instruction byte
- in_ready  out  1  byte accepted when in_valid && in_ready
- ip  out  IP_W  address of next byte to fetch
- flush  in  1  discard state, redirect fetch
- flush_ip  in  IP_W  new ip on flush
- op_valid  out  1  bundle valid
- op_ready  in  1  consumer accepts bundle
- op_code  out  8  opcode byte
- op_ext  out  1  opcode followed 0x0F
- op_seg_ovr  out  1  segment override present
- op_seg  out  2  override segment (0 es, 1 cs, 2 ss, 3 ds)
- op_rep  out  2  bit1 REP present, bit0 1=REPZ/F3, 0=REPNZ/F2
- op_lock  out  1  LOCK present
- op_pcnt  out  PC_W  prefixes consumed
- op_start_ip  out  IP_W  ip of first byte (first prefix) of instruction
- op_fault  out  1  prefix chain exceeded MAX_PREFIX
- op_opsize, op_adsize  out  1 each  0x66/0x67 seen (only with X86_PREFIX_SIZE_EN)

## Operation
- States: S_PREFIX (collecting), S_ESCAPE (after 0x0F), S_HOLD (bundle presented).
- in_ready = !reset && !flush && (state != S_HOLD || op_ready).
- Accepted byte in S_PREFIX: first byte of an instruction (pcnt==0) latches start_ip <= ip.
  - 0x26/2E/36/3E: seg_ovr<=1, seg<=data[4:3]; last override wins.
  - 0xF0: lock<=1. 0xF2/0xF3: rep<={1,data[0]}; last wins.
  - 0x66/0x67: size flags (macro only); otherwise treated as opcode.
  - 0x0F: -> S_ESCAPE.
  - other: op_code<=data, op_ext<=0, -> S_HOLD.
  - prefix when pcnt==MAX_PREFIX: op_code<=data, op_fault<=1, -> S_HOLD.
  - prefix otherwise: pcnt<=pcnt+1.
- S_ESCAPE: next byte -> op_code, op_ext<=1, -> S_HOLD (any value, prefix codes included).
- S_HOLD: op_valid=1, all op_* stable. On op_ready: accumulators clear; a byte accepted in the same cycle is processed as the first byte of the next instruction in S_PREFIX (no bubble).
- ip increments by 1 per accepted byte, wraps mod 2^IP_W.
- flush: priority over all but reset; ip<=flush_ip, accumulators clear, op_valid<=0, -> S_PREFIX; no byte accepted that cycle.
- reset: ip<=RESET_IP, S_PREFIX, op_valid and all op_* outputs 0, in_ready 0.

## Timing
- Bundle visible cycle after opcode byte accepted (latency 1).
- Throughput: one byte per cycle; n-prefix instruction occupies n+1 cycles (+1 for 0x0F).
- op_valid held until op_ready; in_valid may drop anytime, state kept.
- Reset or flush mid-chain: partial prefixes dropped, no bundle emitted.

## Configuration
- X86_PREFIX_SIZE_EN defined: 0x66/0x67 are prefixes, counted in pcnt, reported on op_opsize/op_adsize.
- Undefined: ports absent; 0x66/0x67 decode as ordinary opcodes.

## Structure
- Package x86_pkg: segment constants SEG_ES..SEG_DS, rep encoding constants, state enum, prefix byte constants.
- Single module; prefix classification as a function in x86_pkg; no sub-module.

## Test plan
- Reset, stream 0x90 at ip 8000 -> op_code 90, op_start_ip 8000, no prefixes, ip 8001.
- 0x2E,0xF3,0xA4 with op_ready=1 -> op_seg_ovr 1, op_seg 1, op_rep 2'b11, op_pcnt 2, start_ip = ip of 0x2E.
- 0x26,0x3E,0xF2,0x0F,0x84 -> op_seg 3, op_rep 2'b10, op_ext 1, op_code 84.
- op_ready low 3 cycles with bytes pending -> bundle stable, in_ready 0, no ip advance; then back-to-back bundles without bubble.
- 15 bytes 0xF0 (MAX_PREFIX=14) -> op_fault 1, op_pcnt 14, op_code F0.
- flush after 0x2E with flush_ip 0100 -> no bundle, ip 0100, next 0x90 gives clean bundle start_ip 0100; ip FFFF + byte wraps to 0000.

Source files
------------

// File: rtl/x86_pkg.sv
// Shared definitions for the x86 prefix/opcode fetch front end: segment and
// REP encodings, prefix byte values, FSM state type, and the prefix classifier.
// Optional macro X86_PREFIX_SIZE_EN makes 0x66/0x67 operand/address-size prefixes.
package x86_pkg;

    localparam logic [1:0] SEG_ES = 2'd0;
    localparam logic [1:0] SEG_CS = 2'd1;
    localparam logic [1:0] SEG_SS = 2'd2;
    localparam logic [1:0] SEG_DS = 2'd3;

    localparam logic [1:0] REP_NONE = 2'b00;
    localparam logic [1:0] REP_NZ   = 2'b10;
    localparam logic [1:0] REP_Z    = 2'b11;

    localparam logic [7:0] PFX_ES     = 8'h26;
    localparam logic [7:0] PFX_CS     = 8'h2E;
    localparam logic [7:0] PFX_SS     = 8'h36;
    localparam logic [7:0] PFX_DS     = 8'h3E;
    localparam logic [7:0] PFX_LOCK   = 8'hF0;
    localparam logic [7:0] PFX_REPNZ  = 8'hF2;
    localparam logic [7:0] PFX_REPZ   = 8'hF3;
    localparam logic [7:0] PFX_OPSIZE = 8'h66;
    localparam logic [7:0] PFX_ADSIZE = 8'h67;
    localparam logic [7:0] ESC_0F     = 8'h0F;

    typedef enum logic [1:0] {
        S_PREFIX,
        S_ESCAPE,
        S_HOLD
    } state_t;

    typedef enum logic [2:0] {
        PC_OPCODE,
        PC_SEG,
        PC_LOCK,
        PC_REP,
        PC_OPSIZE,
        PC_ADSIZE,
        PC_ESCAPE
    } pfx_class_t;

    function automatic pfx_class_t classify(input logic [7:0] b);
        pfx_class_t c;
        case (b)
            PFX_ES, PFX_CS, PFX_SS, PFX_DS: c = PC_SEG;
            PFX_LOCK:                       c = PC_LOCK;
            PFX_REPNZ, PFX_REPZ:            c = PC_REP;
`ifdef X86_PREFIX_SIZE_EN
            PFX_OPSIZE:                     c = PC_OPSIZE;
            PFX_ADSIZE:                     c = PC_ADSIZE;
`endif
            ESC_0F:                         c = PC_ESCAPE;
            default:                        c = PC_OPCODE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/x86_prefix_fetch_if.sv
// Byte-port and opcode-bundle signals of the prefix fetch unit.
// Optional macro X86_PREFIX_SIZE_EN adds op_opsize/op_adsize.
interface x86_prefix_fetch_if #(
    parameter int unsigned IP_W       = 16,
    parameter int unsigned MAX_PREFIX = 14
);
    localparam int unsigned PC_W = $clog2(MAX_PREFIX + 1);

    logic            in_valid;
    logic [7:0]      in_data;
    logic            in_ready;
    logic [IP_W-1:0] ip;
    logic            flush;
    logic [IP_W-1:0] flush_ip;
    logic            op_valid;
    logic            op_ready;
    logic [7:0]      op_code;
    logic            op_ext;
    logic            op_seg_ovr;
    logic [1:0]      op_seg;
    logic [1:0]      op_rep;
    logic            op_lock;
    logic [PC_W-1:0] op_pcnt;
    logic [IP_W-1:0] op_start_ip;
    logic            op_fault;
`ifdef X86_PREFIX_SIZE_EN
    logic            op_opsize;
    logic            op_adsize;
`endif

    // Environment side: memory byte port and execute sequencer.
    modport master (
        output in_valid, in_data, flush, flush_ip, op_ready,
        input  in_ready, ip, op_valid, op_code, op_ext, op_seg_ovr, op_seg,
               op_rep, op_lock, op_pcnt, op_start_ip, op_fault
`ifdef X86_PREFIX_SIZE_EN
        , input op_opsize, op_adsize
`endif
    );

    // Fetch unit side.
    modport slave (
        input  in_valid, in_data, flush, flush_ip, op_ready,
        output in_ready, ip, op_valid, op_code, op_ext, op_seg_ovr, op_seg,
               op_rep, op_lock, op_pcnt, op_start_ip, op_fault
`ifdef X86_PREFIX_SIZE_EN
        , output op_opsize, op_adsize
`endif
    );

endinterface

// File: rtl/x86_prefix_fetch.sv
// x86 byte-stream front end: accumulates prefixes, handles the 0x0F escape,
// tracks fetch/start IP and presents one opcode bundle per instruction.
// Optional macro X86_PREFIX_SIZE_EN treats 0x66/0x67 as counted size prefixes.
module x86_prefix_fetch
    import x86_pkg::*;
#(
    parameter int unsigned          IP_W       = 16,
    parameter logic [IP_W-1:0]      RESET_IP   = IP_W'(16'h8000),
    parameter int unsigned          MAX_PREFIX = 14
) (
    input  logic               clock,
    input  logic               reset,
    x86_prefix_fetch_if.slave  bus
);

    localparam int unsigned PC_W = $clog2(MAX_PREFIX + 1);

    state_t          state;
    logic [IP_W-1:0] ip_q;
    logic [IP_W-1:0] start_ip_q;
    logic [7:0]      code_q;
    logic            ext_q;
    logic            seg_ovr_q;
    logic [1:0]      seg_q;
    logic [1:0]      rep_q;
    logic            lock_q;
    logic [PC_W-1:0] pcnt_q;
    logic            fault_q;
    logic            valid_q;
    logic            opsize_q;
    logic            adsize_q;

    logic            in_ready;
    logic            accept;
    pfx_class_t      cls;
    logic            new_instr;
    logic [PC_W-1:0] pcnt_base;
    logic            at_limit;

    // Handshake and byte classification; a byte accepted while a bundle
    // retires starts a fresh instruction with cleared accumulators.
    always_comb begin
        in_ready  = !reset && !bus.flush && (state != S_HOLD || bus.op_ready);
        accept    = bus.in_valid && in_ready;
        cls       = classify(bus.in_data);
        new_instr = (state == S_HOLD) || (pcnt_q == '0);
        pcnt_base = (state == S_HOLD) ? '0 : pcnt_q;
        at_limit  = (pcnt_base == PC_W'(MAX_PREFIX));
    end

    // Prefix/escape/hold FSM with registered bundle outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_PREFIX;
            ip_q       <= RESET_IP;
            start_ip_q <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            seg_ovr_q  <= 1'b0;
            seg_q      <= SEG_ES;
            rep_q      <= REP_NONE;
            lock_q     <= 1'b0;
            pcnt_q     <= '0;
            fault_q    <= 1'b0;
            valid_q    <= 1'b0;
            opsize_q   <= 1'b0;
            adsize_q   <= 1'b0;
        end else if (bus.flush) begin
            state      <= S_PREFIX;
            ip_q       <= bus.flush_ip;
            start_ip_q <= '0;
            code_q     <= '0;
            ext_q      <= 1'b0;
            seg_ovr_q  <= 1'b0;
            seg_q      <= SEG_ES;
            rep_q      <= REP_NONE;
            lock_q     <= 1'b0;
            pcnt_q     <= '0;
            fault_q    <= 1'b0;
            valid_q    <= 1'b0;
            opsize_q   <= 1'b0;
            adsize_q   <= 1'b0;
        end else begin
            // Retire first; any byte handled below overrides individual fields,
            // which gives bubble-free back-to-back bundles.
            if (state == S_HOLD && bus.op_ready) begin
                state     <= S_PREFIX;
                valid_q   <= 1'b0;
                ext_q     <= 1'b0;
                seg_ovr_q <= 1'b0;
                seg_q     <= SEG_ES;
                rep_q     <= REP_NONE;
                lock_q    <= 1'b0;
                pcnt_q    <= '0;
                fault_q   <= 1'b0;
                opsize_q  <= 1'b0;
                adsize_q  <= 1'b0;
            end
            if (accept) begin
                ip_q <= ip_q + 1'b1;
                if (state == S_ESCAPE) begin
                    code_q  <= bus.in_data;
                    ext_q   <= 1'b1;
                    valid_q <= 1'b1;
                    state   <= S_HOLD;
                end else begin
                    if (new_instr) begin
                        start_ip_q <= ip_q;
                    end
                    if (cls == PC_ESCAPE) begin
                        state <= S_ESCAPE;
                    end else if (cls == PC_OPCODE || at_limit) begin
                        code_q  <= bus.in_data;
                        ext_q   <= 1'b0;
                        fault_q <= (cls != PC_OPCODE);
                        valid_q <= 1'b1;
                        state   <= S_HOLD;
                    end else begin
                        pcnt_q <= pcnt_base + 1'b1;
                        case (cls)
                            PC_SEG: begin
                                seg_ovr_q <= 1'b1;
                                seg_q     <= bus.in_data[4:3];
                            end
                            PC_LOCK:   lock_q   <= 1'b1;
                            PC_REP:    rep_q    <= {1'b1, bus.in_data[0]};
                            PC_OPSIZE: opsize_q <= 1'b1;
                            PC_ADSIZE: adsize_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.ip          = ip_q;
    assign bus.op_valid    = valid_q;
    assign bus.op_code     = code_q;
    assign bus.op_ext      = ext_q;
    assign bus.op_seg_ovr  = seg_ovr_q;
    assign bus.op_seg      = seg_q;
    assign bus.op_rep      = rep_q;
    assign bus.op_lock     = lock_q;
    assign bus.op_pcnt     = pcnt_q;
    assign bus.op_start_ip = start_ip_q;
    assign bus.op_fault    = fault_q;
`ifdef X86_PREFIX_SIZE_EN
    assign bus.op_opsize   = opsize_q;
    assign bus.op_adsize   = adsize_q;
`else
    logic unused_size;
    assign unused_size = opsize_q ^ adsize_q;
`endif

endmodule
